// File: rtl/game_pkg.sv
// Shared command encoding, FSM states and direction arbitration helpers
// for the front-end that feeds game_control.
package game_pkg;

    localparam int OP_R       = 0;
    localparam int OP_D       = 1;
    localparam int OP_L       = 2;
    localparam int OP_U       = 3;
    localparam int OP_RESTART = 4;
    localparam int OP_W       = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t CMD_NONE    = 5'b00000;
    localparam op_t CMD_RESTART = 5'b10000;

    typedef struct packed {
        logic [3:0] win;     // one-hot winning direction, zero if none
        logic [2:0] lose_n;  // directions that lost this cycle
    } arb_t;

    // Fixed priority u > l > d > r.
    function automatic logic [3:0] dir_prio(input logic [3:0] d);
        logic [3:0] w;
        w = 4'b0;
        if (d[OP_U])      w[OP_U] = 1'b1;
        else if (d[OP_L]) w[OP_L] = 1'b1;
        else if (d[OP_D]) w[OP_D] = 1'b1;
        else if (d[OP_R]) w[OP_R] = 1'b1;
        return w;
    endfunction

    function automatic arb_t arbitrate(input logic [3:0] d);
        arb_t a;
        a.win    = dir_prio(d);
        a.lose_n = 3'($countones(d & ~a.win));
        return a;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the level only
// moves after DEBOUNCE_CYCLES consecutive samples of the new value.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_pipe;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe <= 2'b00;
            cnt       <= '0;
            level     <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], raw};
            // Any sample agreeing with the current level restarts the count.
            if (sync_pipe[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_pipe[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/move_cmd_scheduler.sv
// Debounces the five buttons, queues direction presses and issues them to
// the kernel one at a time; restart pre-empts the queue. MOVE_REPEAT_EN adds hold-to-repeat.
module move_cmd_scheduler
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4,
    parameter int DROP_W          = 8
`ifdef MOVE_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
`endif
) (
    input  logic                            CLK_100M,
    input  logic                            RST,
    input  logic [OP_W-1:0]                 btn_raw,
    input  logic                            gameover,
    input  logic                            cmd_ready,
    input  logic                            cmd_done,
    output logic                            cmd_valid,
    output logic [OP_W-1:0]                 cmd,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [DROP_W-1:0]               dropped_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [OP_W-1:0] lvl, lvl_q, ev;
    logic [3:0]      dir_ev, cand;
    logic            restart_ev, restart_pend;
    arb_t            arb;
    logic            full, push, pop, drop_full;
    logic [2:0]      drop_inc;
    logic [DROP_W:0] drop_sum;
    logic [FIFO_DEPTH-1:0][3:0] mem;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    state_t          state;

    for (genvar i = 0; i < OP_W; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (CLK_100M),
            .rst   (RST),
            .raw   (btn_raw[i]),
            .level (lvl[i])
        );
    end

    always_ff @(posedge CLK_100M or posedge RST) begin
        if (RST) lvl_q <= '0;
        else     lvl_q <= lvl;
    end

    assign ev         = lvl & ~lvl_q;
    assign restart_ev = ev[OP_RESTART];

`ifdef MOVE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [3:0]    held_top, rep_dir, rep_ev;
    logic [RW-1:0] rep_cnt, rep_tgt;
    logic          rep_first;

    // A change of the top held direction (press, release or takeover) restarts the delay.
    assign held_top = dir_prio(lvl[3:0]);
    assign rep_tgt  = rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign rep_ev   = (held_top == rep_dir && rep_cnt == rep_tgt) ? rep_dir : 4'b0;

    always_ff @(posedge CLK_100M or posedge RST) begin
        if (RST) begin
            rep_dir   <= 4'b0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (held_top != rep_dir) begin
            rep_dir   <= held_top;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_ev != 4'b0) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (rep_dir != 4'b0) begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end

    assign dir_ev = ev[OP_U:OP_R] | rep_ev;
`else
    assign dir_ev = ev[OP_U:OP_R];
`endif

    // Restart swallows same-cycle directions uncounted; gameover discards them silently.
    assign cand      = (restart_ev || gameover) ? 4'b0 : dir_ev;
    assign arb       = arbitrate(cand);
    assign full      = (fifo_level == LW'(FIFO_DEPTH));
    assign pop       = (state == S_IDLE) && !restart_pend && !restart_ev &&
                       (fifo_level != '0) && !gameover;
    assign push      = (arb.win != 4'b0) && (!full || pop);
    assign drop_full = (arb.win != 4'b0) && !push;
    assign drop_inc  = arb.lose_n + {2'b00, drop_full};
    assign drop_sum  = {1'b0, dropped_cnt} + (DROP_W+1)'(drop_inc);

    always_ff @(posedge CLK_100M or posedge RST) begin
        if (RST) dropped_cnt <= '0;
        else if (drop_sum[DROP_W]) dropped_cnt <= '1;
        else dropped_cnt <= drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge CLK_100M) begin
        if (push) mem[wr_ptr] <= arb.win;
    end

    always_ff @(posedge CLK_100M or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (restart_ev) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge CLK_100M or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            cmd_valid    <= 1'b0;
            cmd          <= CMD_NONE;
            restart_pend <= 1'b0;
        end else begin
            if (restart_ev) restart_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (restart_pend || restart_ev) begin
                        cmd       <= CMD_RESTART;
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end else if (pop) begin
                        cmd       <= {1'b0, mem[rd_ptr]};
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A restart pressed during the transfer cycle stays pending.
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd       <= CMD_NONE;
                        if (cmd[OP_RESTART] && !restart_ev) restart_pend <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cmd_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/move_cmd_scheduler.md
Name: move_cmd_scheduler

Overview:
- Sits between the raw push-buttons/switches and game_control.
- Synchronises and debounces the five user inputs, then turns presses into single-cycle command events.
- Queues direction moves in a small FIFO and issues them one at a time to the game kernel over a valid/ready + done handshake.
- Restart is handled specially: it pre-empts the queue, and moves are suppressed while gameover is high.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles an input must be stable before its debounced level changes (10 ms at 100 MHz).
- FIFO_DEPTH, 4, direction-command queue entries; power of two, minimum 2.
- DROP_W, 8, width of the saturating dropped-command counter.
- REPEAT_DELAY, 50000000, hold time before auto-repeat starts (used only with MOVE_REPEAT_EN).
- REPEAT_PERIOD, 15000000, auto-repeat interval (used only with MOVE_REPEAT_EN).

Ports:
- CLK_100M  in  1  system clock, 100 MHz.
- RST  in  1  reset; asynchronous, active-high.
- btn_raw  in  5  {restart,u,l,d,r}, asynchronous, active-high.
- gameover  in  1  from game_control; high means no moves are accepted.
- cmd_ready  in  1  kernel can accept a command this cycle.
- cmd_done  in  1  single-cycle pulse; the kernel has finished the last command.
- cmd_valid  out  1  command presented.
- cmd  out  5  one-hot {restart,u,l,d,r}; all zero when cmd_valid is low.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries currently queued.
- dropped_cnt  out  DROP_W  saturating count of discarded move events.

Behaviour:
- Reset values: cmd_valid=0, cmd=0, fifo_level=0, dropped_cnt=0, FSM=IDLE, all debounced levels=0, restart_pend=0.
  - Reset mid-handshake abandons the command with no further cmd_valid.
- Input path:
  - Each bit passes a 2-FF synchroniser, then its own debouncer.
  - The debounced level updates after DEBOUNCE_CYCLES consecutive cycles of a differing synchronised value.
  - A glitch shorter than that restarts the counter.
  - An event is the rising edge of a debounced level. Falling edges do nothing.
  - Latency from a clean raw edge to the event: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Event arbitration, per cycle:
  - Restart event: set restart_pend, flush the FIFO (level goes to 0 next cycle), and discard any direction events that cycle without counting them.
  - Otherwise, direction events are considered only if gameover=0; with gameover=1 they are discarded silently.
  - Fixed priority u > l > d > r. The winner is enqueued; each loser increments dropped_cnt.
  - A winner that finds the FIFO full is also dropped and counted.
  - dropped_cnt saturates at 2^DROP_W-1.
- FSM (IDLE, ISSUE, WAIT):
  - IDLE:
    - If restart_pend, load cmd=restart one-hot and go to ISSUE.
    - Else if the FIFO is non-empty and gameover=0, pop the head into cmd and go to ISSUE.
  - ISSUE:
    - cmd_valid=1 with cmd held stable until cmd_ready=1; the transfer occurs in that cycle.
    - The next cycle has cmd_valid=0; a restart command also clears restart_pend. Then go to WAIT.
    - A restart event arriving while a move is in ISSUE does not retract it (valid stays asserted); restart issues after that move completes.
  - WAIT:
    - Return to IDLE on cmd_done.
    - cmd_done outside WAIT is ignored.
    - If cmd_done arrives in the same cycle as the transfer, it is ignored; done must come at least 1 cycle after the transfer.
  - Minimum spacing between two transfers: 3 cycles (ISSUE→WAIT→IDLE→ISSUE).
  - gameover rising while moves are queued: the queue is retained but stalls in IDLE. A restart flushes it.
- FIFO:
  - Enqueue and dequeue in the same cycle are allowed, including when full.
  - fifo_level is registered and exact. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro MOVE_REPEAT_EN.
- When defined:
  - A direction whose debounced level stays high for REPEAT_DELAY cycles after its press event generates a repeat event.
  - Further repeat events follow every REPEAT_PERIOD cycles while the button is held.
  - Only the highest-priority held direction repeats.
  - Repeat events go through the same arbitration, gameover and FIFO rules, and are counted if dropped.
  - Release stops repeats immediately.
- When undefined: no repeat logic is synthesised; one press gives exactly one event.

Decomposition:
- Shared package game_pkg:
  - Operation bit indices OP_R=0, OP_D=1, OP_L=2, OP_U=3, OP_RESTART=4; OP_W=5.
  - FSM state encoding: S_IDLE, S_ISSUE, S_WAIT.
  - The same one-hot command encoding used by game_control.
- Natural sub-module: btn_debounce (synchroniser + counter + rising-edge pulse), instantiated 5× via generate.

Test Plan (DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4 for simulation):
- Single press: hold btn_raw=5'b01000 for 10 cycles, cmd_ready=1 → exactly one cmd_valid with cmd=01000, 8 cycles after the edge. After cmd_done, FSM returns to IDLE; dropped_cnt=0.
- Bounce: toggle bit0 every 2 cycles for 20 cycles, then hold → one event only, cmd=00001.
- Overflow: hold cmd_ready=0 and press u,l,d,r,u,l in sequence → fifo_level=4 with the first press issuing while the rest queue (level caps at 4); dropped_cnt=1 for the press beyond capacity. Releasing cmd_ready drains the queue in order.
- Simultaneous press of u and r (5'b01001) → cmd=01000 queued, dropped_cnt increments to 1.
- Restart pre-emption: queue 3 moves with cmd_ready=0, then press restart → fifo_level=0 next cycle; the in-flight command completes, then cmd=10000 issues and no queued moves follow.
- Gameover: gameover=1, press l → nothing issued, dropped_cnt unchanged. Then press restart → cmd=10000 is issued.
